// File: rtl/seq_divider_unit.sv
// Multi-cycle unsigned radix-2 restoring divider.
// Responder on the execute stage's divide valid/done handshake.
module seq_divider_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic               busy,
    output logic [2*WIDTH-1:0] c
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             last;

    // The shifted remainder keeps its top bit so divisors above 2^(WIDTH-1)
    // still divide correctly; diff[WIDTH] is the borrow.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        if (diff[WIDTH]) begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

    assign last = (count == CW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (!valid) begin
                    state_next = IDLE;
                end else if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state == BUSY);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            count <= '0;
            c     <= '0;
        end else begin
            if (state == IDLE && valid) begin
                quo   <= a;
                dvs   <= b;
                rem   <= '0;
                count <= CW'(WIDTH);
            end else if (state == BUSY && valid) begin
                rem   <= rem_next;
                quo   <= quo_next;
                count <= count - CW'(1);
                if (last) begin
                    c <= {rem_next, quo_next};
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider_unit.sv
// Self-checking bench for seq_divider_unit: directed vectors,
// multi-cycle corner sequences and random operands vs. plain arithmetic.
module tb_seq_divider_unit;

    logic        clk;
    logic        reset;
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        done;
    logic        busy;
    logic [63:0] c;

    int tests;
    int fails;

    seq_divider_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .valid (valid),
        .a     (a),
        .b     (b),
        .done  (done),
        .busy  (busy),
        .c     (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called at a negedge; raises valid and waits (bounded) for done.
    // lat counts rising edges from the request to the done cycle.
    task automatic run_op(input logic [31:0] oa, input logic [31:0] ob,
                          input logic [63:0] prev,
                          output logic [63:0] oc, output int lat,
                          output int nbusy, output int hold_bad);
        a = oa;
        b = ob;
        valid = 1'b1;
        lat = 0;
        nbusy = 0;
        hold_bad = 0;
        oc = '0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                oc = c;
                break;
            end
            if (busy) nbusy++;
            if (c !== prev) hold_bad = 1;
        end
    endtask

    initial begin
        vec_t        vecs[6];
        logic [63:0] got;
        logic [63:0] prev;
        logic [31:0] ra;
        logic [31:0] rb;
        int          lat;
        int          nb;
        int          hb;
        int          n2;

        tests = 0;
        fails = 0;
        vecs[0] = '{32'd100,        32'd7,          {32'd2, 32'd14}};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          {32'd0, 32'hFFFF_FFFF}};
        vecs[2] = '{32'd5,          32'hFFFF_FFFF,  {32'd5, 32'd0}};
        vecs[3] = '{32'd0,          32'd3,          64'd0};
        vecs[4] = '{32'h1234_5678,  32'd0,          {32'h1234_5678, 32'hFFFF_FFFF}};
        vecs[5] = '{32'hFFFF_FFFF,  32'h8000_0001,  {32'h7FFF_FFFE, 32'd1}};

        reset = 1'b1;
        valid = 1'b0;
        a = '0;
        b = '0;
        #2;
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_c", c, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            prev = c;
            run_op(vecs[i].a, vecs[i].b, prev, got, lat, nb, hb);
            valid = 1'b0;
            chk($sformatf("vec%0d_c", i), got, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
            chk($sformatf("vec%0d_busy_cycles", i), 64'(nb), 64'd32);
            chk($sformatf("vec%0d_c_held", i), 64'(hb), 64'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_done_after", i), {63'd0, done}, 64'd0);
            chk($sformatf("vec%0d_c_stable", i), c, vecs[i].exp);
        end

        // Abort at busy cycle 10, then a new request must complete alone.
        prev = c;
        a = 32'd100;
        b = 32'd7;
        valid = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_busy_before", {63'd0, busy}, 64'd1);
        valid = 1'b0;
        @(negedge clk);
        chk("abort_busy_after", {63'd0, busy}, 64'd0);
        chk("abort_no_done", {63'd0, done}, 64'd0);
        chk("abort_c_unchanged", c, prev);
        run_op(32'd9, 32'd2, prev, got, lat, nb, hb);
        valid = 1'b0;
        chk("abort_next_c", got, {32'd1, 32'd4});
        chk("abort_next_latency", 64'(lat), 64'd33);
        chk("abort_c_held", 64'(hb), 64'd0);
        @(negedge clk);
        chk("abort_single_done", {63'd0, done}, 64'd0);

        // Back-to-back with valid held: new operands in the bubble cycle.
        prev = c;
        run_op(32'd100, 32'd7, prev, got, lat, nb, hb);
        chk("b2b_first_c", got, {32'd2, 32'd14});
        @(negedge clk);
        chk("b2b_bubble_done", {63'd0, done}, 64'd0);
        chk("b2b_bubble_busy", {63'd0, busy}, 64'd0);
        a = 32'd81;
        b = 32'd9;
        n2 = 0;
        for (int n = 2; n <= 100; n++) begin
            @(negedge clk);
            if (done) begin
                n2 = n;
                break;
            end
        end
        valid = 1'b0;
        chk("b2b_spacing", 64'(n2), 64'd34);
        chk("b2b_second_c", c, {32'd0, 32'd9});
        @(negedge clk);

        // Asynchronous reset between edges in the middle of an operation.
        a = 32'd100;
        b = 32'd7;
        valid = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_mid_busy_before", {63'd0, busy}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_done", {63'd0, done}, 64'd0);
        chk("rst_mid_c", c, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(32'd100, 32'd7, 64'd0, got, lat, nb, hb);
        valid = 1'b0;
        chk("rst_after_c", got, {32'd2, 32'd14});
        chk("rst_after_latency", 64'(lat), 64'd33);
        @(negedge clk);

        // Random operands, with small and zero divisors mixed in.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(0, 15));
                1: rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            prev = c;
            run_op(ra, rb, prev, got, lat, nb, hb);
            valid = 1'b0;
            chk($sformatf("rand%0d_c a=%h b=%h", i, ra, rb), got, ref_div(ra, rb));
            chk($sformatf("rand%0d_latency", i), 64'(lat), 64'd33);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
